// File: rtl/arb4_pkg.sv
// Purpose: shared constants, FSM state type and helpers for the 4-way round-robin arbiter.
// Latency: none; declarations only.
// Backpressure: none.
package arb4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Convert a requester index to its one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot2(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Purpose: round-robin winner selection over 4 requesters, starting the scan just after ptr.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is used.
// Ports: req[3:0] request level, ptr[1:0] last granted index,
//        win_idx[1:0] selected requester, any = at least one request present.
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotating by ptr+1 puts the requester after the last owner at bit 0,
  // so a plain lowest-bit priority encoder gives round-robin order.
  assign start = ptr + 2'd1;
  assign dbl   = {req, req};
  assign rot   = dbl[start +: N_REQ];
  assign any   = |req;

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // Undo the rotation; the 2-bit add wraps mod 4.
  assign win_idx = start + off;

endmodule

// File: rtl/arb4_rr_scheduler.sv
// Purpose: 4-requester round-robin arbiter; grant held until rel, owner req drop or (optional) timeout.
// Latency: req seen at edge t -> gnt after edge t+1; one forced idle cycle between grants.
// Backpressure: non-owners wait in place (no preemption); owner releases with rel or by dropping req.
// Ports: clk, nrst (async active-low); req[3:0], rel in; gnt[3:0], gnt_idx[1:0], gnt_vld, timeout out.
// Optional feature macro: ARB_TIMEOUT_EN (hold counter forcing release after MAX_HOLD cycles).
module arb4_rr_scheduler
  import arb4_pkg::*;
#(
  parameter int unsigned      MAX_HOLD = 15,
  parameter logic [IDX_W-1:0] PTR_INIT = 2'd3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] win_idx;
  logic             any;
  logic             hold_hit;
  logic             release_now;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .any     (any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;

  assign hold_hit = (cnt_q == HOLD_LAST);
  assign timeout  = to_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`else
  // MAX_HOLD only matters with the hold counter; sink it so it stays referenced.
  logic unused_cfg;
  assign unused_cfg = ^8'(MAX_HOLD);
  assign hold_hit   = 1'b0;
  assign timeout    = 1'b0;
`endif

  // rel and an owner req drop in the same cycle are a single release.
  assign release_now = rel | ~req[idx_q] | hold_hit;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_INIT;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = OWN;
          gnt_d   = onehot2(win_idx);
          idx_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWN: begin
        if (release_now) begin
          // gnt_idx is left alone so it keeps the last owner while idle.
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
          to_d    = hold_hit;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_arb4_rr_scheduler.sv
// Purpose: self-checking bench for arb4_rr_scheduler (vector table + multi-cycle corner sequences).
// Latency: each vector is driven at negedge and checked 1 time unit after the following posedge.
// Backpressure: n/a.
module tb_arb4_rr_scheduler;

  logic       clk;
  logic       nrst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  arb4_rr_scheduler #(
    .MAX_HOLD (4),
    .PTR_INIT (2'd3)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] idx;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[26];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] ei, input logic et);
    total_cnt++;
    if (gnt === eg && gnt_idx === ei && gnt_vld === (|eg) && timeout === et)
      pass_cnt++;
    else
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, expected gnt=%b idx=%0d vld=%b to=%b",
               nm, gnt, gnt_idx, gnt_vld, timeout, eg, ei, |eg, et);
  endtask

  task automatic step(input string nm, input logic [3:0] r, input logic rl,
                      input logic [3:0] eg, input logic [1:0] ei, input logic et);
    exp_t e;
    @(negedge clk);
    req = r;
    rel = rl;
    sb.push_back('{eg, ei, et});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: scoreboard empty, got gnt=%b, expected an entry", nm, gnt);
    end else begin
      e = sb.pop_front();
      check(nm, e.gnt, e.idx, e.to);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rotation with all four requesting, rel one cycle after each grant.
    vecs[0]  = '{4'hF, 1'b1 ^ 1'b1, 4'b0001, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 4'b0000, 2'd0};
    vecs[2]  = '{4'hF, 1'b0, 4'b0010, 2'd1};
    vecs[3]  = '{4'hF, 1'b1, 4'b0000, 2'd1};
    vecs[4]  = '{4'hF, 1'b0, 4'b0100, 2'd2};
    vecs[5]  = '{4'hF, 1'b1, 4'b0000, 2'd2};
    vecs[6]  = '{4'hF, 1'b0, 4'b1000, 2'd3};
    vecs[7]  = '{4'hF, 1'b1, 4'b0000, 2'd3};
    vecs[8]  = '{4'hF, 1'b0, 4'b0001, 2'd0};
    vecs[9]  = '{4'hF, 1'b1, 4'b0000, 2'd0};
    // Owner 1 keeps the grant while req[3] arrives; 3 wins two edges after rel.
    vecs[10] = '{4'h2, 1'b0, 4'b0010, 2'd1};
    vecs[11] = '{4'hA, 1'b0, 4'b0010, 2'd1};
    vecs[12] = '{4'hA, 1'b0, 4'b0010, 2'd1};
    vecs[13] = '{4'hA, 1'b1, 4'b0000, 2'd1};
    vecs[14] = '{4'h8, 1'b0, 4'b1000, 2'd3};
    // Owner 3 drops req without rel; pending 0 wins after wrap.
    vecs[15] = '{4'h9, 1'b0, 4'b1000, 2'd3};
    vecs[16] = '{4'h1, 1'b0, 4'b0000, 2'd3};
    vecs[17] = '{4'h1, 1'b0, 4'b0001, 2'd0};
    // rel together with req drop, then rel in IDLE with no requests.
    vecs[18] = '{4'h0, 1'b1, 4'b0000, 2'd0};
    vecs[19] = '{4'h0, 1'b1, 4'b0000, 2'd0};
    vecs[20] = '{4'h0, 1'b0, 4'b0000, 2'd0};
    // ptr=0: requester 0 only wins after scanning 1,2,3; then 1 beats 0.
    vecs[21] = '{4'h1, 1'b0, 4'b0001, 2'd0};
    vecs[22] = '{4'h3, 1'b0, 4'b0001, 2'd0};
    vecs[23] = '{4'h3, 1'b1, 4'b0000, 2'd0};
    vecs[24] = '{4'h3, 1'b0, 4'b0010, 2'd1};
    vecs[25] = '{4'h0, 1'b0, 4'b0000, 2'd1};

    nrst = 1'b0;
    req  = 4'h0;
    rel  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 26; i++)
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rel, vecs[i].gnt, vecs[i].idx, 1'b0);

    // Requester 2 holds without rel (ptr=1 so it wins directly).
    step("hold_t1", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
    step("hold_t2", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
    step("hold_t3", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
    step("hold_t4", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
`ifdef ARB_TIMEOUT_EN
    step("timeout_drop", 4'h4, 1'b0, 4'b0000, 2'd2, 1'b1);
    step("timeout_regrant", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
`else
    step("no_timeout_t5", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
    step("no_timeout_t6", 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0);
`endif

    // Asynchronous reset in the middle of a cycle drops the grant at once.
    @(negedge clk);
    check("pre_async_reset", 4'b0100, 2'd2, 1'b0);
    nrst = 1'b0;
    #1;
    check("async_reset_drop", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    req  = 4'h0;

    // PTR_INIT restored: requester 0 first again.
    step("post_reset_g0", 4'hF, 1'b0, 4'b0001, 2'd0, 1'b0);
    step("post_reset_rel", 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0);
    step("post_reset_g1", 4'hF, 1'b0, 4'b0010, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
